// File: rtl/gshare_branch_predictor_pkg.sv
// Shared encodings and helpers for the gshare branch predictor.
package bp_pkg;

   // 2-bit saturating counter encodings
   localparam logic [1:0] SNT       = 2'b00;
   localparam logic [1:0] WNT       = 2'b01;
   localparam logic [1:0] WT        = 2'b10;
   localparam logic [1:0] ST        = 2'b11;
   localparam logic [1:0] CNT_RESET = WT;

   // Next counter value after an outcome; saturates at SNT and ST.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      if (taken) nxt = (cnt == ST)  ? ST  : cnt + 2'd1;
      else       nxt = (cnt == SNT) ? SNT : cnt - 2'd1;
      return nxt;
   endfunction

   // PHT index from PC[pht_w+1:2], optionally XORed with the zero-extended
   // history. The caller truncates the result to pht_w bits.
   function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] hist,
                                             input logic gshare_en, input int pht_w);
      logic [31:0] mask;
      logic [31:0] pcb;
      mask = (32'd1 << pht_w) - 32'd1;
      pcb  = (pc >> 2) & mask;
      return gshare_en ? (pcb ^ (hist & mask)) : pcb;
   endfunction

endpackage

// File: rtl/gshare_branch_predictor_btb.sv
// Direct-mapped tagged BTB. Registered read port; the read sees the array
// contents from before a same-edge write.
module bp_btb #(
   parameter int BTB_WIDTH = 4,
   parameter int TAG_WIDTH = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rd_en,
   input  logic [31:0] rd_pc,
   output logic        rd_hit,
   output logic [31:0] rd_target,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic [31:0] wr_target
);

   localparam int ENTRIES = 1 << BTB_WIDTH;

   logic                 valid_q  [ENTRIES];
   logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
   logic [31:0]          target_q [ENTRIES];

   logic [BTB_WIDTH-1:0] ridx, widx;
   logic [TAG_WIDTH-1:0] rtag, wtag;
   logic                 hit_c;

   assign ridx  = rd_pc[BTB_WIDTH+1:2];
   assign widx  = wr_pc[BTB_WIDTH+1:2];
   assign rtag  = rd_pc[BTB_WIDTH+TAG_WIDTH+1:BTB_WIDTH+2];
   assign wtag  = wr_pc[BTB_WIDTH+TAG_WIDTH+1:BTB_WIDTH+2];
   assign hit_c = valid_q[ridx] && (tag_q[ridx] == rtag);

   // Valid bits: cleared on reset, set by a write
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (wr_en) begin
         valid_q[widx] <= 1'b1;
      end
   end

   // Tag and target storage; contents are qualified by the valid bit
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         tag_q[widx]    <= wtag;
         target_q[widx] <= wr_target;
      end
   end

   // Registered read; target forced to 0 on a miss, outputs hold when idle
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rd_hit    <= 1'b0;
         rd_target <= 32'd0;
      end else if (rd_en) begin
         rd_hit    <= hit_c;
         rd_target <= hit_c ? target_q[ridx] : 32'd0;
      end
   end

endmodule

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor with a tagged BTB. Queried by IF,
// trained at commit; the GHR only ever holds committed outcomes.
module gshare_branch_predictor
   import bp_pkg::*;
#(
   parameter int PHT_WIDTH = 6,
   parameter int HIST_LEN  = 6,   // 1..PHT_WIDTH
   parameter int GSHARE_EN = 1,
   parameter int BTB_WIDTH = 4,
   parameter int TAG_WIDTH = 8
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                query_en,
   input  logic [31:0]         query_PC,
   output logic                result_out_en,
   output logic                result_out,
   output logic                result_target_hit,
   output logic [31:0]         result_target,
   output logic [HIST_LEN-1:0] result_hist,
   input  logic                update_en,
   input  logic [31:0]         update_PC,
   input  logic [HIST_LEN-1:0] update_hist,
   input  logic                update_result,
   input  logic [31:0]         update_target
);

   localparam int PHT_ENTRIES = 1 << PHT_WIDTH;

   logic [1:0]           pht [PHT_ENTRIES];
   logic [HIST_LEN-1:0]  ghr, ghr_next;
   logic [PHT_WIDTH-1:0] qidx, uidx;
   logic                 q_fire, u_fire;

   assign q_fire = query_en  & rdy_in;
   assign u_fire = update_en & rdy_in;

   // Update uses the history snapshot that produced the prediction, not the
   // current GHR, so training hits the same entry the query read.
   assign qidx = PHT_WIDTH'(pht_index(query_PC,  32'(ghr),         GSHARE_EN != 0, PHT_WIDTH));
   assign uidx = PHT_WIDTH'(pht_index(update_PC, 32'(update_hist), GSHARE_EN != 0, PHT_WIDTH));

   generate
      if (HIST_LEN == 1) begin : g_hist1
         assign ghr_next = update_result;
      end else begin : g_histn
         assign ghr_next = {ghr[HIST_LEN-2:0], update_result};
      end
   endgenerate

   // PHT training: saturating counter step at the committed index
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= CNT_RESET;
      end else if (u_fire) begin
         pht[uidx] <= sat_update(pht[uidx], update_result);
      end
   end

   // Committed global history
   always_ff @(posedge clk_in) begin
      if (rst_in)      ghr <= '0;
      else if (u_fire) ghr <= ghr_next;
   end

   // Direction response; reads pre-update state on a same-edge update
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         result_out_en <= 1'b0;
         result_out    <= 1'b0;
         result_hist   <= '0;
      end else if (rdy_in) begin
         result_out_en <= query_en;
         if (query_en) begin
            result_out  <= pht[qidx][1];
            result_hist <= ghr;
         end
      end
   end

   bp_btb #(
      .BTB_WIDTH (BTB_WIDTH),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_btb (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rd_en     (q_fire),
      .rd_pc     (query_PC),
      .rd_hit    (result_target_hit),
      .rd_target (result_target),
      .wr_en     (u_fire & update_result),
      .wr_pc     (update_PC),
      .wr_target (update_target)
   );

endmodule
